// File: rtl/dmem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_pkg
// Shared types and constants for the data-memory arbiter.
//   dmem_arb_state_e   : arbiter FSM encoding (IDLE / WAIT / RESP / ERR)
//   DMEM_ARB_TIMEOUT_W : default width of the starvation counter
// Optional feature macro used by the importing files: DMEM_ARB_TIMEOUT_EN
// -----------------------------------------------------------------------------
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    DMEM_ARB_IDLE = 2'd0,
    DMEM_ARB_WAIT = 2'd1,
    DMEM_ARB_RESP = 2'd2,
    DMEM_ARB_ERR  = 2'd3
  } dmem_arb_state_e;

  localparam int DMEM_ARB_TIMEOUT_W = 8;

endpackage

// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
// Bundles the CPU data-memory signals, the auxiliary req/gnt port and the
// data-memory port that surround the arbiter.
//   slave  : the arbiter's view (takes CPU/aux requests and memory read data,
//            drives grants, read returns and the memory request)
//   master : the surrounding system's view (CPU, aux requester and memory)
// Parameters: ADDR_W (address width), DATA_W (data width).
// -----------------------------------------------------------------------------
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  // CPU load/store path
  logic [ADDR_W-1:0] cpu_addr_i;
  logic [DATA_W-1:0] cpu_wdata_i;
  logic              cpu_memwrite_i;
  logic              cpu_memread_i;
  logic [3:0]        cpu_sign_mask_i;
  logic [DATA_W-1:0] cpu_rdata_o;

  // Auxiliary requester
  logic              aux_req_i;
  logic              aux_we_i;
  logic [ADDR_W-1:0] aux_addr_i;
  logic [DATA_W-1:0] aux_wdata_i;
  logic [3:0]        aux_sign_mask_i;
  logic              aux_gnt_o;
  logic              aux_rvalid_o;
  logic [DATA_W-1:0] aux_rdata_o;
  logic              aux_err_o;

  // Data memory
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_memwrite_o;
  logic              mem_memread_o;
  logic [3:0]        mem_sign_mask_o;
  logic [DATA_W-1:0] mem_rdata_i;

  modport slave (
    input  cpu_addr_i, cpu_wdata_i, cpu_memwrite_i, cpu_memread_i, cpu_sign_mask_i,
    output cpu_rdata_o,
    input  aux_req_i, aux_we_i, aux_addr_i, aux_wdata_i, aux_sign_mask_i,
    output aux_gnt_o, aux_rvalid_o, aux_rdata_o, aux_err_o,
    output mem_addr_o, mem_wdata_o, mem_memwrite_o, mem_memread_o, mem_sign_mask_o,
    input  mem_rdata_i
  );

  modport master (
    output cpu_addr_i, cpu_wdata_i, cpu_memwrite_i, cpu_memread_i, cpu_sign_mask_i,
    input  cpu_rdata_o,
    output aux_req_i, aux_we_i, aux_addr_i, aux_wdata_i, aux_sign_mask_i,
    input  aux_gnt_o, aux_rvalid_o, aux_rdata_o, aux_err_o,
    input  mem_addr_o, mem_wdata_o, mem_memwrite_o, mem_memread_o, mem_sign_mask_o,
    output mem_rdata_i
  );

endinterface

// File: rtl/dmem_arb_timeout.sv
// -----------------------------------------------------------------------------
// dmem_arb_timeout
// Saturating starvation counter for the arbiter's WAIT state.
//   clk_i   : clock
//   rstn_i  : asynchronous active-low reset (counter -> 0)
//   clr_i   : synchronous clear (has priority over en_i)
//   en_i    : count enable; stops at all-ones, never wraps
//   term_o  : counter is at its terminal (all-ones) value
// Parameter: W (counter width).
// Only instantiated when DMEM_ARB_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module dmem_arb_timeout #(
  parameter int W = 8
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic clr_i,
  input  logic en_i,
  output logic term_o
);

  logic [W-1:0] cnt_q, cnt_d;

  assign term_o = &cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !term_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares the core's single data-memory port between the CPU load/store path
// (absolute priority, zero added latency) and one auxiliary requester that
// only gets cycles where the CPU issues no access.
//   clk_i  : core clock
//   rstn_i : asynchronous active-low reset
//   bus    : dmem_arbiter_if.slave -- CPU signals, aux req/gnt/rvalid/rdata/err,
//            and the data-memory request/read-data port
// Parameters: ADDR_W, DATA_W, TIMEOUT_W (starvation counter width).
// Optional feature: DMEM_ARB_TIMEOUT_EN enables the WAIT starvation timeout
// (aux_err_o pulse and ERR state); without it aux_err_o is tied low.
// -----------------------------------------------------------------------------
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT_W = DMEM_ARB_TIMEOUT_W
) (
  input  logic           clk_i,
  input  logic           rstn_i,
  dmem_arbiter_if.slave  bus
);

  dmem_arb_state_e   state_q, state_d;
  logic [DATA_W-1:0] rdata_hold_q;
  logic [ADDR_W-1:0] mem_addr_mux;
  logic              cpu_busy;
  logic              can_grant;
  logic              timeout_hit;

  assign cpu_busy = bus.cpu_memread_i | bus.cpu_memwrite_i;

`ifdef DMEM_ARB_TIMEOUT_EN
  logic cnt_term;

  // Counter runs only while waiting; any other state restarts it from zero.
  dmem_arb_timeout #(.W(TIMEOUT_W)) u_timeout (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .clr_i  (state_q != DMEM_ARB_WAIT),
    .en_i   (state_q == DMEM_ARB_WAIT),
    .term_o (cnt_term)
  );

  // Timeout beats a coincident CPU-idle cycle: the request is abandoned.
  assign timeout_hit = (state_q == DMEM_ARB_WAIT) && bus.aux_req_i && cnt_term;
`else
  logic [TIMEOUT_W-1:0] unused_timeout_w;
  assign unused_timeout_w = '0;
  assign timeout_hit      = 1'b0;
`endif

  // IDLE and WAIT grant under the same condition; RESP/ERR never grant.
  assign can_grant = rstn_i && bus.aux_req_i && !cpu_busy && !timeout_hit &&
                     ((state_q == DMEM_ARB_IDLE) || (state_q == DMEM_ARB_WAIT));

  // State register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= DMEM_ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DMEM_ARB_IDLE, DMEM_ARB_WAIT: begin
        if (!bus.aux_req_i) begin
          state_d = DMEM_ARB_IDLE;
        end else if (timeout_hit) begin
          state_d = DMEM_ARB_ERR;
        end else if (!cpu_busy) begin
          // Writes complete in the grant cycle; reads need the return cycle.
          state_d = bus.aux_we_i ? DMEM_ARB_IDLE : DMEM_ARB_RESP;
        end else begin
          state_d = DMEM_ARB_WAIT;
        end
      end
      DMEM_ARB_RESP: state_d = DMEM_ARB_IDLE;
      DMEM_ARB_ERR: begin
`ifdef DMEM_ARB_TIMEOUT_EN
        state_d = bus.aux_req_i ? DMEM_ARB_ERR : DMEM_ARB_IDLE;
`else
        state_d = DMEM_ARB_IDLE;
`endif
      end
      default: state_d = DMEM_ARB_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.aux_gnt_o    = can_grant;
    bus.aux_rvalid_o = (state_q == DMEM_ARB_RESP);
    bus.aux_err_o    = timeout_hit;
    // Read data is live in the return cycle, then comes from the hold register.
    bus.aux_rdata_o  = (state_q == DMEM_ARB_RESP) ? bus.mem_rdata_i : rdata_hold_q;
    bus.cpu_rdata_o  = bus.mem_rdata_i;

    mem_addr_mux        = bus.cpu_addr_i;
    bus.mem_wdata_o     = bus.cpu_wdata_i;
    bus.mem_memwrite_o  = bus.cpu_memwrite_i;
    bus.mem_memread_o   = bus.cpu_memread_i;
    bus.mem_sign_mask_o = bus.cpu_sign_mask_i;
    if (can_grant) begin
      mem_addr_mux        = bus.aux_addr_i;
      bus.mem_wdata_o     = bus.aux_wdata_i;
      bus.mem_memwrite_o  = bus.aux_we_i;
      bus.mem_memread_o   = !bus.aux_we_i;
      bus.mem_sign_mask_o = bus.aux_sign_mask_i;
    end
    bus.mem_addr_o = mem_addr_mux;
  end

  // Aux read-data hold register; a reset during RESP discards the response.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rdata_hold_q <= '0;
    end else if (state_q == DMEM_ARB_RESP) begin
      rdata_hold_q <= bus.mem_rdata_i;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Self-checking bench for dmem_arbiter: directed scenarios followed by random
// CPU/aux traffic, checked every cycle against a transaction-level model
// (shadow memory, "an aux request is served on the first CPU-idle cycle that
// does not follow an aux read grant", read data returned the next cycle).
// Optional feature macro: DMEM_ARB_TIMEOUT_EN selects the timeout scenario.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

  localparam int TW = 8;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_W(TW)) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus)
  );

  // Stimulus variables
  logic        cpu_rd, cpu_wr;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [3:0]  cpu_mask;
  logic        aux_req, aux_we;
  logic [31:0] aux_addr, aux_wdata;
  logic [3:0]  aux_mask;

  assign bus.cpu_memread_i   = cpu_rd;
  assign bus.cpu_memwrite_i  = cpu_wr;
  assign bus.cpu_addr_i      = cpu_addr;
  assign bus.cpu_wdata_i     = cpu_wdata;
  assign bus.cpu_sign_mask_i = cpu_mask;
  assign bus.aux_req_i       = aux_req;
  assign bus.aux_we_i        = aux_we;
  assign bus.aux_addr_i      = aux_addr;
  assign bus.aux_wdata_i     = aux_wdata;
  assign bus.aux_sign_mask_i = aux_mask;

  function automatic logic [31:0] init_word(input int i);
    return (i == 16) ? 32'hDEADBEEF : 32'h1000_0000 + i * 32'h0101;
  endfunction

  // Data memory: 64 words, registered read, one-cycle latency
  logic [31:0] ram [64];
  logic [31:0] mem_rdata_q;
  bit          ram_init_done;
  assign bus.mem_rdata_i = mem_rdata_q;

  always @(posedge clk) begin
    if (!ram_init_done) begin
      for (int i = 0; i < 64; i++) ram[i] <= init_word(i);
      ram_init_done <= 1'b1;
    end else if (bus.mem_memwrite_o) begin
      ram[bus.mem_addr_o[7:2]] <= bus.mem_wdata_o;
    end
    mem_rdata_q <= ram[bus.mem_addr_o[7:2]];
  end

  // Reference model state
  logic [31:0] shadow [64];
  logic        m_prev_rd_gnt, m_prev_cpu_rd;
  logic [31:0] m_rd_val, m_hold, m_cpu_rd_val;
  logic        last_gnt, last_gnt_obs, last_err;
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check outputs at the falling edge, advance the model,
  // return 1 time unit after the rising edge.
  task automatic cycle();
    logic        busy, e_gnt, e_rv, e_we, e_re;
    logic [31:0] e_rdata, e_addr, e_wdata;
    logic [3:0]  e_mask;
    int          ai, ci;
    @(negedge clk);
    busy    = cpu_rd | cpu_wr;
    e_gnt   = rstn && aux_req && !busy && !m_prev_rd_gnt;
    e_rv    = rstn && m_prev_rd_gnt;
    e_rdata = !rstn ? 32'h0 : (m_prev_rd_gnt ? m_rd_val : m_hold);
    if (e_gnt) begin
      e_addr = aux_addr; e_wdata = aux_wdata; e_we = aux_we; e_re = !aux_we; e_mask = aux_mask;
    end else begin
      e_addr = cpu_addr; e_wdata = cpu_wdata; e_we = cpu_wr; e_re = cpu_rd; e_mask = cpu_mask;
    end
    chk("aux_gnt",   bus.aux_gnt_o, e_gnt);
    chk("aux_rvalid", bus.aux_rvalid_o, e_rv);
    chk("aux_rdata", bus.aux_rdata_o, e_rdata);
    chk("mem_addr",  bus.mem_addr_o, e_addr);
    chk("mem_wdata", bus.mem_wdata_o, e_wdata);
    chk("mem_we",    bus.mem_memwrite_o, e_we);
    chk("mem_re",    bus.mem_memread_o, e_re);
    chk("mem_mask",  bus.mem_sign_mask_o, e_mask);
    if (rstn && m_prev_cpu_rd) chk("cpu_rdata", bus.cpu_rdata_o, m_cpu_rd_val);
`ifndef DMEM_ARB_TIMEOUT_EN
    chk("aux_err", bus.aux_err_o, 1'b0);
`endif
    last_err     = bus.aux_err_o;
    last_gnt_obs = bus.aux_gnt_o;
    last_gnt     = e_gnt;
    ai = int'(aux_addr[7:2]);
    ci = int'(cpu_addr[7:2]);
    if (!rstn) begin
      m_prev_rd_gnt = 1'b0; m_prev_cpu_rd = 1'b0; m_hold = 32'h0;
    end else begin
      if (m_prev_rd_gnt) m_hold = m_rd_val;
      m_prev_cpu_rd = cpu_rd;
      m_cpu_rd_val  = shadow[ci];
      if (e_gnt && !aux_we) m_rd_val = shadow[ai];
      m_prev_rd_gnt = e_gnt && !aux_we;
      if (e_gnt && aux_we) shadow[ai] = aux_wdata;
      else if (cpu_wr)     shadow[ci] = cpu_wdata;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_cpu(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    cpu_rd = rd; cpu_wr = wr; cpu_addr = a; cpu_wdata = d; cpu_mask = 4'($urandom_range(0, 15));
  endtask

  task automatic set_aux(input logic we, input logic [31:0] a, input logic [31:0] d);
    aux_req = 1'b1; aux_we = we; aux_addr = a; aux_wdata = d; aux_mask = 4'($urandom_range(0, 15));
  endtask

  initial begin
    int gnt_cnt, err_cnt, err_at;
    for (int i = 0; i < 64; i++) shadow[i] = init_word(i);
    m_prev_rd_gnt = 1'b0; m_prev_cpu_rd = 1'b0; m_hold = 32'h0;
    m_rd_val = 32'h0; m_cpu_rd_val = 32'h0;

    // Reset with a pending aux read: grant must stay low
    rstn = 1'b0;
    set_cpu(1'b0, 1'b0, 32'h0000_0010, 32'h0);
    set_aux(1'b0, 32'h0000_0040, 32'h0);
    repeat (2) cycle();
    chk("rst_rvalid", bus.aux_rvalid_o, 1'b0);
    chk("rst_rdata",  bus.aux_rdata_o, 32'h0);
    chk("rst_err",    bus.aux_err_o, 1'b0);
    rstn = 1'b1;

    // Aux read of 0x40 with the CPU idle
    cycle();
    aux_req = 1'b0;
    cycle();
    chk("rd_deadbeef", bus.aux_rdata_o, 32'hDEADBEEF);
    cycle();
    chk("rd_hold", bus.aux_rdata_o, 32'hDEADBEEF);

    // Aux write to 0x44 while the CPU loads 0x44 for three cycles
    set_aux(1'b1, 32'h0000_0044, 32'h1234_5678);
    set_cpu(1'b1, 1'b0, 32'h0000_0044, 32'h0);
    repeat (3) cycle();
    set_cpu(1'b0, 1'b0, 32'h0000_0020, 32'h0);
    cycle();
    chk("wr_grant_4th", last_gnt_obs, 1'b1);
    aux_req = 1'b0;
    set_cpu(1'b1, 1'b0, 32'h0000_0044, 32'h0);
    cycle();
    chk("cpu_load_44", bus.cpu_rdata_o, 32'h1234_5678);
    set_cpu(1'b0, 1'b0, 32'h0000_0020, 32'h0);
    cycle();

    // CPU store collides with an aux read request
    set_cpu(1'b0, 1'b1, 32'h0000_0080, 32'hCAFE_F00D);
    set_aux(1'b0, 32'h0000_0044, 32'h0);
    cycle();
    set_cpu(1'b0, 1'b0, 32'h0000_0020, 32'h0);
    cycle();
    aux_req = 1'b0;
    cycle();
    chk("collide_rd", bus.aux_rdata_o, 32'h1234_5678);

    // Reset pulse during the read-return cycle
    set_aux(1'b0, 32'h0000_0040, 32'h0);
    cycle();
    aux_req = 1'b0;
    rstn = 1'b0;
    cycle();
    rstn = 1'b1;
    chk("rst_resp_hold", bus.aux_rdata_o, 32'h0);
    cycle();
    chk("rst_resp_hold2", bus.aux_rdata_o, 32'h0);

`ifdef DMEM_ARB_TIMEOUT_EN
    // Starvation timeout: CPU always busy, request held
    set_aux(1'b1, 32'h0000_0048, 32'h5555_AAAA);
    set_cpu(1'b1, 1'b0, 32'h0000_0010, 32'h0);
    gnt_cnt = 0; err_cnt = 0; err_at = -1;
    for (int i = 0; i < (1 << TW) + 4; i++) begin
      cycle();
      if (last_gnt_obs) gnt_cnt++;
      if (last_err) begin err_cnt++; err_at = i; end
    end
    chk("to_err_count", err_cnt, 1);
    chk("to_err_cycle", err_at, 1 << TW);
    chk("to_no_grant", gnt_cnt, 0);
    aux_req = 1'b0;
    cycle();
    set_cpu(1'b0, 1'b0, 32'h0000_0010, 32'h0);
    set_aux(1'b1, 32'h0000_0048, 32'h5555_AAAA);
    cycle();
    chk("to_recover_grant", last_gnt_obs, 1'b1);
    aux_req = 1'b0;
    cycle();
`else
    // Long starvation without timeout: grant on the first idle cycle
    set_aux(1'b1, 32'h0000_0048, 32'h5555_AAAA);
    set_cpu(1'b1, 1'b0, 32'h0000_0010, 32'h0);
    gnt_cnt = 0; err_cnt = 0; err_at = -1;
    for (int i = 0; i < 300; i++) begin
      cycle();
      if (last_gnt_obs) gnt_cnt++;
      if (last_err) begin err_cnt++; err_at = i; end
    end
    chk("starve_no_grant", gnt_cnt, 0);
    chk("starve_no_err", err_cnt, 0);
    set_cpu(1'b0, 1'b0, 32'h0000_0010, 32'h0);
    cycle();
    chk("starve_grant", last_gnt_obs, 1'b1);
    aux_req = 1'b0;
    cycle();
`endif

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      int r;
      r = int'($urandom_range(0, 3));
      set_cpu(r == 1, r == 2, {24'h0, 6'($urandom_range(0, 63)), 2'b00}, $urandom);
      if (last_gnt) aux_req = 1'b0;
      if (!aux_req && $urandom_range(0, 2) != 0)
        set_aux(1'($urandom_range(0, 1)), {24'h0, 6'($urandom_range(0, 63)), 2'b00}, $urandom);
      cycle();
    end
    aux_req = 1'b0;
    set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the core's single data-memory port between the pipeline's load/store path and one auxiliary requester, such as a debug/readout engine or a DMA. The block sits between the cpu data-memory signals and the data memory. The pipeline has no stall input, so the CPU always has absolute priority. The auxiliary port gets only cycles where the CPU issues no access, through a req/gnt handshake with one-cycle read return.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT_W, 8, starvation counter width (used only with the timeout feature)

Ports (one clock; reset is asynchronous and active-low):
- clk_i  in  1  core clock
- rstn_i  in  1  asynchronous active-low reset
- cpu_addr_i  in  ADDR_W  CPU load/store address (EX stage)
- cpu_wdata_i  in  DATA_W  CPU store data
- cpu_memwrite_i  in  1  CPU store strobe
- cpu_memread_i  in  1  CPU load strobe
- cpu_sign_mask_i  in  4  CPU sign/byte mask
- cpu_rdata_o  out  DATA_W  load data to the MEM stage
- aux_req_i  in  1  auxiliary request; held with its fields stable until aux_gnt_o
- aux_we_i  in  1  1 = write, 0 = read
- aux_addr_i  in  ADDR_W  auxiliary address
- aux_wdata_i  in  DATA_W  auxiliary write data
- aux_sign_mask_i  in  4  auxiliary sign/byte mask
- aux_gnt_o  out  1  access issued to memory this cycle
- aux_rvalid_o  out  1  auxiliary read data valid
- aux_rdata_o  out  DATA_W  auxiliary read data, held until the next aux read
- aux_err_o  out  1  starvation timeout pulse (timeout feature only)
- mem_addr_o, mem_wdata_o, mem_memwrite_o, mem_memread_o, mem_sign_mask_o  out  ADDR_W/DATA_W/1/1/4  to data memory
- mem_rdata_i  in  DATA_W  memory read data, one cycle after the address

## Operation
- cpu_busy = cpu_memread_i | cpu_memwrite_i.
- CPU path is pure pass-through with no added latency. cpu_rdata_o = mem_rdata_i at all times.
- mem_* carry the aux fields only in a cycle where aux_gnt_o = 1. Otherwise mem_* carry the CPU fields.
- FSM states:
  - IDLE: aux_req_i & !cpu_busy → aux_gnt_o = 1. A read goes to RESP; a write stays in IDLE. aux_req_i & cpu_busy → WAIT.
  - WAIT: grant on the first cycle with !cpu_busy, with the same next-state rule as IDLE. aux_req_i dropped → IDLE (tolerated protocol violation, no access).
  - RESP: aux_rvalid_o = 1 and aux_rdata_o = mem_rdata_i. The value is captured into the hold register on the clock edge. No grant is issued in RESP (one outstanding aux read). Next state IDLE; a still-asserted new request is evaluated from IDLE.
  - ERR: see Configuration.
- Simultaneous CPU access and aux request: CPU wins, aux_gnt_o = 0.
- The requester drops aux_req_i in the cycle after aux_gnt_o. A request still held is treated as a new request.

## Timing
- Reset values: FSM = IDLE, aux_gnt_o = 0, aux_rvalid_o = 0, aux_rdata_o = 0, aux_err_o = 0, starvation counter = 0.
- While rstn_i = 0, aux_gnt_o is forced to 0 and mem_* pass the CPU fields.
- aux_gnt_o is combinational from state, aux_req_i and cpu_busy.
- Aux read latency: grant in cycle N, aux_rvalid_o in cycle N+1. aux_rdata_o is stable from N+1 until the next RESP.
- Minimum aux read-to-read spacing is 2 cycles. Back-to-back aux writes can be issued every cycle.
- Reset asserted in RESP: the response is discarded, aux_rvalid_o never pulses, and the hold register clears to 0.

## Configuration
- DMEM_ARB_TIMEOUT_EN defined:
  - A TIMEOUT_W-bit counter increments each cycle in WAIT and clears on leaving WAIT. It saturates at all-ones and never wraps.
  - When the counter reaches 2^TIMEOUT_W−1 in WAIT: aux_err_o pulses for 1 cycle, the FSM goes to ERR, and the request is dropped with no grant.
  - ERR holds until aux_req_i = 0, then goes to IDLE.
- DMEM_ARB_TIMEOUT_EN undefined: no counter and no ERR state. aux_err_o is tied to 0 and WAIT persists indefinitely.

## Structure
- State encodings (IDLE/WAIT/RESP/ERR) and the default TIMEOUT_W go in the shared rv32i defines include as `DMEM_ARB_*` constants.
- One sub-module, dmem_arb_timeout: a saturating counter with clear/enable and a terminal flag. It is instantiated only under DMEM_ARB_TIMEOUT_EN.
- The cpu top instantiates dmem_arbiter between its data_mem_* outputs and the memory.

## Test plan
- Aux read to addr 0x40 (memory holds 0xDEADBEEF), CPU idle → aux_gnt_o in cycle N, aux_rvalid_o = 1 with aux_rdata_o = 0xDEADBEEF in N+1, value held after.
- Aux write 0x12345678 to 0x44 while the CPU loads from 0x44 for 3 cycles → no grant for 3 cycles (FSM in WAIT), grant on the 4th. A later CPU load from 0x44 returns 0x12345678.
- CPU store and aux read request in the same cycle → mem_* show the CPU fields, aux_gnt_o = 0. The aux read is granted the next idle cycle.
- Reset pulse during RESP → aux_rvalid_o stays 0 and aux_rdata_o = 0 after reset.
- With DMEM_ARB_TIMEOUT_EN and TIMEOUT_W = 3, CPU busy continuously, aux_req_i held → aux_err_o pulses once 7 cycles after entering WAIT, no grant. FSM returns to IDLE after aux_req_i falls.
- Without the macro, the same stimulus → aux_err_o stays 0. Grant occurs on the first CPU-idle cycle, even after 300 busy cycles.
